// File: rtl/cam_pkg.sv
// Shared types and defaults for the CAM sequencing controller.
//   cam_state_e : controller phase (IDLE, WRITE, SEARCH, RESULT)
//   cam_gnt_e   : type of the most recent grant, used for round-robin arbitration
//   CAM_WIDTH_DEF / CAM_DEPTH_DEF : default key width and entry count
package cam_pkg;

    localparam int unsigned CAM_WIDTH_DEF = 8;
    localparam int unsigned CAM_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SEARCH,
        RESULT
    } cam_state_e;

    typedef enum logic {
        GNT_WRITE,
        GNT_SEARCH
    } cam_gnt_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder.
//   vec_i : DEPTH-bit request vector
//   idx_o : index of the lowest set bit (0 when vec_i is all zero)
//   any_o : at least one bit of vec_i is set
module cam_prio_enc #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned IDXW  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] vec_i,
    output logic [IDXW-1:0]  idx_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (vec_i[i-1]) begin
                idx_o = IDXW'(i - 1);
            end
        end
    end

endmodule

// File: rtl/cam_ctrl.sv
// Sequencing controller for a DEPTH-entry CAM array of WIDTH-bit match cells.
// Arbitrates tag inserts against tag lookups, allocates the lowest free entry,
// drives one-hot write enables / search strobe to the cells and priority-
// encodes the valid-masked match vector into a hit index.
//
// Optional feature macro: CAM_MULTIHIT_EN (adds rslt_multi_o).
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   flush_i             : synchronous invalidate of every entry, aborts any op
//   wr_req_i/wr_data_i  : insert request and key (key sampled in grant cycle)
//   wr_gnt_o/wr_idx_o   : insert grant pulse and the entry allocated
//   srch_req_i/srch_key_i : lookup request and key (key sampled in grant cycle)
//   srch_gnt_o          : lookup grant pulse
//   rslt_valid_o/rslt_hit_o/rslt_idx_o : lookup result, two cycles after grant
//   rslt_multi_o        : (CAM_MULTIHIT_EN) two or more valid entries matched
//   cam_we_o/cam_wdat_o : one-hot write enable and write data to the cells
//   cam_search_o/cam_key_o : search strobe and key to the cells
//   cam_match_i         : per-entry match from the cells (negedge-registered)
//   full_o/count_o      : all entries valid / number of valid entries
module cam_ctrl
    import cam_pkg::*;
#(
    parameter  int unsigned WIDTH = CAM_WIDTH_DEF,
    parameter  int unsigned DEPTH = CAM_DEPTH_DEF,
    localparam int unsigned IDXW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             wr_req_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_gnt_o,
    output logic [IDXW-1:0]  wr_idx_o,
    input  logic             srch_req_i,
    input  logic [WIDTH-1:0] srch_key_i,
    output logic             srch_gnt_o,
    output logic             rslt_valid_o,
    output logic             rslt_hit_o,
    output logic [IDXW-1:0]  rslt_idx_o,
`ifdef CAM_MULTIHIT_EN
    output logic             rslt_multi_o,
`endif
    output logic [DEPTH-1:0] cam_we_o,
    output logic [WIDTH-1:0] cam_wdat_o,
    output logic             cam_search_o,
    output logic [WIDTH-1:0] cam_key_o,
    input  logic [DEPTH-1:0] cam_match_i,
    output logic             full_o,
    output logic [IDXW:0]    count_o
);

    cam_state_e       state_q,      state_d;
    cam_gnt_e         rr_last_q,    rr_last_d;
    logic [DEPTH-1:0] valid_q,      valid_d;
    logic [DEPTH-1:0] mvec_q,       mvec_d;
    logic [DEPTH-1:0] cam_we_q,     cam_we_d;
    logic [WIDTH-1:0] cam_wdat_q,   cam_wdat_d;
    logic             cam_search_q, cam_search_d;
    logic [WIDTH-1:0] cam_key_q,    cam_key_d;
    logic             rslt_valid_q, rslt_valid_d;

    logic [IDXW-1:0]  free_idx;
    logic             free_any;
    logic [IDXW-1:0]  hit_idx;
    logic             hit_any;
    logic             wr_gnt_c;
    logic             srch_gnt_c;
    logic             wr_elig;
    logic [IDXW:0]    count_c;

    cam_prio_enc #(.DEPTH(DEPTH)) u_free_enc (
        .vec_i (~valid_q),
        .idx_o (free_idx),
        .any_o (free_any)
    );

    cam_prio_enc #(.DEPTH(DEPTH)) u_hit_enc (
        .vec_i (mvec_q),
        .idx_o (hit_idx),
        .any_o (hit_any)
    );

    assign wr_elig = wr_req_i && free_any;

    // Data/key/mvec registers are cleared outside their own phase so the
    // cell-facing buses and the hit encoder read zero whenever idle.
    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        valid_d      = valid_q;
        mvec_d       = '0;
        cam_we_d     = '0;
        cam_wdat_d   = '0;
        cam_search_d = 1'b0;
        cam_key_d    = '0;
        rslt_valid_d = 1'b0;
        wr_gnt_c     = 1'b0;
        srch_gnt_c   = 1'b0;

        if (flush_i) begin
            state_d = IDLE;
            valid_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A write wins when uncontested or when search went last.
                    if (wr_elig && (!srch_req_i || rr_last_q == GNT_SEARCH)) begin
                        wr_gnt_c   = 1'b1;
                        rr_last_d  = GNT_WRITE;
                        cam_we_d   = DEPTH'(1) << free_idx;
                        cam_wdat_d = wr_data_i;
                        state_d    = WRITE;
                    end else if (srch_req_i) begin
                        srch_gnt_c   = 1'b1;
                        rr_last_d    = GNT_SEARCH;
                        cam_search_d = 1'b1;
                        cam_key_d    = srch_key_i;
                        state_d      = SEARCH;
                    end
                end
                WRITE: begin
                    valid_d = valid_q | cam_we_q;
                    state_d = IDLE;
                end
                SEARCH: begin
                    mvec_d       = cam_match_i & valid_q;
                    rslt_valid_d = 1'b1;
                    state_d      = RESULT;
                end
                RESULT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rr_last_q    <= GNT_WRITE;
            valid_q      <= '0;
            mvec_q       <= '0;
            cam_we_q     <= '0;
            cam_wdat_q   <= '0;
            cam_search_q <= 1'b0;
            cam_key_q    <= '0;
            rslt_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            valid_q      <= valid_d;
            mvec_q       <= mvec_d;
            cam_we_q     <= cam_we_d;
            cam_wdat_q   <= cam_wdat_d;
            cam_search_q <= cam_search_d;
            cam_key_q    <= cam_key_d;
            rslt_valid_q <= rslt_valid_d;
        end
    end

    always_comb begin
        count_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_c = count_c + {{IDXW{1'b0}}, valid_q[i]};
        end
    end

    // Grants are decided in the IDLE cycle itself; holding them low while
    // reset is asserted keeps every output at zero during reset.
    assign wr_gnt_o     = wr_gnt_c & rst;
    assign srch_gnt_o   = srch_gnt_c & rst;
    assign wr_idx_o     = wr_gnt_o ? free_idx : '0;

    // A flush landing in RESULT suppresses the strobe for that cycle.
    assign rslt_valid_o = rslt_valid_q & ~flush_i;
    assign rslt_hit_o   = rslt_valid_o & hit_any;
    assign rslt_idx_o   = hit_idx;
`ifdef CAM_MULTIHIT_EN
    // Two or more bits set iff clearing the lowest set bit leaves something.
    assign rslt_multi_o = rslt_valid_o & (|(mvec_q & (mvec_q - DEPTH'(1))));
`endif

    assign cam_we_o     = cam_we_q;
    assign cam_wdat_o   = cam_wdat_q;
    assign cam_search_o = cam_search_q;
    assign cam_key_o    = cam_key_q;
    assign full_o       = ~free_any;
    assign count_o      = count_c;

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed + randomized bench for cam_ctrl with a behavioural CAM cell array
// and an entry-table reference model.
module tb_cam_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned IDXW  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush_i = 1'b0;
    logic             wr_req_i = 1'b0;
    logic [WIDTH-1:0] wr_data_i = '0;
    logic             wr_gnt_o;
    logic [IDXW-1:0]  wr_idx_o;
    logic             srch_req_i = 1'b0;
    logic [WIDTH-1:0] srch_key_i = '0;
    logic             srch_gnt_o;
    logic             rslt_valid_o;
    logic             rslt_hit_o;
    logic [IDXW-1:0]  rslt_idx_o;
`ifdef CAM_MULTIHIT_EN
    logic             rslt_multi_o;
`endif
    logic [DEPTH-1:0] cam_we_o;
    logic [WIDTH-1:0] cam_wdat_o;
    logic             cam_search_o;
    logic [WIDTH-1:0] cam_key_o;
    logic [DEPTH-1:0] cam_match_i = '0;
    logic             full_o;
    logic [IDXW:0]    count_o;

    cam_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .wr_req_i     (wr_req_i),
        .wr_data_i    (wr_data_i),
        .wr_gnt_o     (wr_gnt_o),
        .wr_idx_o     (wr_idx_o),
        .srch_req_i   (srch_req_i),
        .srch_key_i   (srch_key_i),
        .srch_gnt_o   (srch_gnt_o),
        .rslt_valid_o (rslt_valid_o),
        .rslt_hit_o   (rslt_hit_o),
        .rslt_idx_o   (rslt_idx_o),
`ifdef CAM_MULTIHIT_EN
        .rslt_multi_o (rslt_multi_o),
`endif
        .cam_we_o     (cam_we_o),
        .cam_wdat_o   (cam_wdat_o),
        .cam_search_o (cam_search_o),
        .cam_key_o    (cam_key_o),
        .cam_match_i  (cam_match_i),
        .full_o       (full_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    // CAM cell array: cells power up holding 0, compare on the negedge.
    logic [WIDTH-1:0] cells [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) cells[i] = '0;

    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (cam_we_o[i]) cells[i] <= cam_wdat_o;
    end

    always @(negedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            cam_match_i[i] <= cam_search_o && (cells[i] == cam_key_o);
    end

    // Reference model: which entries hold a live key, and what key.
    logic             mv [DEPTH];
    logic [WIDTH-1:0] mk [DEPTH];

    int errors = 0;
    int checks = 0;

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = 1'b0;
            mk[i] = '0;
        end
    endfunction

    function automatic int model_free();
        for (int i = 0; i < DEPTH; i++) if (!mv[i]) return i;
        return -1;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mv[i]) n++;
        return n;
    endfunction

    function automatic int model_hit(input logic [WIDTH-1:0] k);
        for (int i = 0; i < DEPTH; i++) if (mv[i] && mk[i] == k) return i;
        return -1;
    endfunction

    function automatic int model_nhits(input logic [WIDTH-1:0] k);
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mv[i] && mk[i] == k) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [WIDTH-1:0] key);
        bit got = 0;
        int exp_idx = model_free();
        wr_req_i  = 1'b1;
        wr_data_i = key;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (wr_gnt_o) begin
                got = 1;
                check("wr_idx", 32'(wr_idx_o), 32'(exp_idx));
            end
            tick();
        end
        wr_req_i = 1'b0;
        check("wr_gnt_seen", 32'(got), 32'd1);
        @(negedge clk);
        check("cam_we", 32'(cam_we_o), 32'(1) << exp_idx);
        check("cam_wdat", 32'(cam_wdat_o), 32'(key));
        if (exp_idx >= 0) begin
            mv[exp_idx] = 1'b1;
            mk[exp_idx] = key;
        end
        tick();
    endtask

    task automatic do_search(input logic [WIDTH-1:0] key);
        bit got = 0;
        int exp_hit = model_hit(key);
        srch_req_i = 1'b1;
        srch_key_i = key;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (srch_gnt_o) got = 1;
            tick();
        end
        srch_req_i = 1'b0;
        check("srch_gnt_seen", 32'(got), 32'd1);
        @(negedge clk);
        check("cam_search", 32'(cam_search_o), 32'd1);
        check("cam_key", 32'(cam_key_o), 32'(key));
        check("rslt_early", 32'(rslt_valid_o), 32'd0);
        tick();
        @(negedge clk);
        check("rslt_valid", 32'(rslt_valid_o), 32'd1);
        check("rslt_hit", 32'(rslt_hit_o), 32'(exp_hit >= 0));
        check("rslt_idx", 32'(rslt_idx_o), (exp_hit >= 0) ? 32'(exp_hit) : 32'd0);
`ifdef CAM_MULTIHIT_EN
        check("rslt_multi", 32'(rslt_multi_o), 32'(model_nhits(key) >= 2));
`endif
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]       gseq;
        int               n;
        int               widx;
        logic [WIDTH-1:0] k;

        model_clear();

        // Reset with both requests pending: everything must stay quiet.
        wr_req_i   = 1'b1;
        srch_req_i = 1'b1;
        wr_data_i  = 8'hC3;
        srch_key_i = 8'hC3;
        #12;
        check("rst_wr_gnt", 32'(wr_gnt_o), 32'd0);
        check("rst_srch_gnt", 32'(srch_gnt_o), 32'd0);
        check("rst_rslt_valid", 32'(rslt_valid_o), 32'd0);
        check("rst_cam_we", 32'(cam_we_o), 32'd0);
        check("rst_cam_search", 32'(cam_search_o), 32'd0);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Contested requests from reset: search, write, search, write.
        gseq = '0;
        n    = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            check("gnt_exclusive", 32'(wr_gnt_o & srch_gnt_o), 32'd0);
            if (wr_gnt_o || srch_gnt_o) begin
                gseq[n] = wr_gnt_o;
                if (wr_gnt_o) begin
                    widx = model_free();
                    check("alt_wr_idx", 32'(wr_idx_o), 32'(widx));
                    mv[widx] = 1'b1;
                    mk[widx] = 8'hC3;
                end
                n++;
            end
            tick();
        end
        wr_req_i   = 1'b0;
        srch_req_i = 1'b0;
        check("alt_sequence", 32'(gseq), 32'b1010);
        repeat (3) tick();
        check("alt_count", 32'(count_o), 32'(model_count()));

        // Flush in IDLE with a search pending: no grant, all entries gone.
        srch_req_i = 1'b1;
        flush_i    = 1'b1;
        @(negedge clk);
        check("flush_no_gnt", 32'(srch_gnt_o), 32'd0);
        tick();
        flush_i    = 1'b0;
        srch_req_i = 1'b0;
        model_clear();
        @(negedge clk);
        check("flush_count", 32'(count_o), 32'd0);
        tick();

        // Empty CAM, cells holding 0, key 0: invalid entries must not hit.
        do_search(8'h00);

        do_write(8'h3A);
        do_search(8'h3A);
        do_write(8'h55);
        do_write(8'h55);
        do_search(8'h55);
        check("count_3", 32'(count_o), 32'd3);

        // Random mix until the CAM fills.
        for (int it = 0; it < 200 && model_count() < DEPTH; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                do_write(8'($urandom));
                check("count_track", 32'(count_o), 32'(model_count()));
            end else if ($urandom_range(0, 1) == 1) begin
                do_search(mk[$urandom_range(0, model_count() - 1)]);
            end else begin
                do_search(8'($urandom));
            end
        end
        check("full", 32'(full_o), 32'd1);
        check("count_full", 32'(count_o), 32'(DEPTH));

        // Full: a held write never gets granted; searches still served.
        wr_req_i  = 1'b1;
        wr_data_i = 8'hEE;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (wr_gnt_o) n++;
            tick();
        end
        check("full_no_wr_gnt", 32'(n), 32'd0);
        do_search(mk[7]);
        do_search(8'($urandom));
        wr_req_i = 1'b0;
        check("full_count_hold", 32'(count_o), 32'(DEPTH));

        // Flush during SEARCH: result dropped, stored keys forgotten.
        k = mk[2];
        srch_req_i = 1'b1;
        srch_key_i = k;
        n = 0;
        for (int c = 0; c < 20 && n == 0; c++) begin
            @(negedge clk);
            if (srch_gnt_o) n = 1;
            tick();
        end
        srch_req_i = 1'b0;
        check("fs_gnt_seen", 32'(n), 32'd1);
        flush_i = 1'b1;
        n = 0;
        @(negedge clk);
        check("fs_in_search", 32'(cam_search_o), 32'd1);
        if (rslt_valid_o) n++;
        tick();
        flush_i = 1'b0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rslt_valid_o) n++;
            tick();
        end
        check("fs_no_rslt", 32'(n), 32'd0);
        check("fs_count", 32'(count_o), 32'd0);
        do_search(k);

        // Asynchronous reset in the middle of a search.
        do_write(8'h9C);
        srch_req_i = 1'b1;
        srch_key_i = 8'h9C;
        n = 0;
        for (int c = 0; c < 20 && n == 0; c++) begin
            @(negedge clk);
            if (srch_gnt_o) n = 1;
            tick();
        end
        srch_req_i = 1'b0;
        @(negedge clk);
        check("ar_in_search", 32'(cam_search_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("ar_cam_search", 32'(cam_search_o), 32'd0);
        check("ar_cam_key", 32'(cam_key_o), 32'd0);
        check("ar_count", 32'(count_o), 32'd0);
        tick();
        tick();
        check("ar_rslt_valid", 32'(rslt_valid_o), 32'd0);
        rst = 1'b1;
        model_clear();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
